// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax datapath: float32 width, handy float
// constants and the state encoding of the divider feeder.
package softmax_pkg;

    localparam int FP_W = 32;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h00000000;
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F800000;
    localparam logic [FP_W-1:0] FP_QNAN = 32'hFFC00000;

    typedef enum logic [2:0] {
        LOAD_EXP,
        LOAD_SUM,
        SEND_A,
        SEND_B,
        WAIT_Z,
        PUT_Z
    } feeder_state_e;

endpackage

// File: rtl/softmax_exp_buffer.sv
// Holds one vector of float32 exponentials: synchronous write port and a
// combinational read port addressed by the feeder's element index.
module softmax_exp_buffer
    import softmax_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [FP_W-1:0]  wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [FP_W-1:0]  rdata_o
);

    logic [FP_W-1:0] mem_q [N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/softmax_div_feeder.sv
// Softmax normalisation stage: buffers N exponentials and their sum, then
// feeds exp[i]/sum through the divider one element at a time, in index order.
module softmax_div_feeder
    import softmax_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FP_W-1:0]  input_exp,
    input  logic             input_exp_stb,
    output logic             input_exp_ack,
    input  logic [FP_W-1:0]  input_sum,
    input  logic             input_sum_stb,
    output logic             input_sum_ack,
    output logic [FP_W-1:0]  div_a,
    output logic             div_a_stb,
    input  logic             div_a_ack,
    output logic [FP_W-1:0]  div_b,
    output logic             div_b_stb,
    input  logic             div_b_ack,
    input  logic [FP_W-1:0]  div_z,
    input  logic             div_z_stb,
    output logic             div_z_ack,
    output logic [FP_W-1:0]  output_z,
    output logic [IDX_W-1:0] output_idx,
    output logic             output_last,
    output logic             output_z_stb,
    input  logic             output_z_ack
);

    feeder_state_e    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [FP_W-1:0]  sum_q, sum_d;
    logic             expAck_q, expAck_d;
    logic             sumAck_q, sumAck_d;
    logic [FP_W-1:0]  divA_q, divA_d;
    logic             divAStb_q, divAStb_d;
    logic [FP_W-1:0]  divB_q, divB_d;
    logic             divBStb_q, divBStb_d;
    logic             zAck_q, zAck_d;
    logic [FP_W-1:0]  outZ_q, outZ_d;
    logic [IDX_W-1:0] outIdx_q, outIdx_d;
    logic             outLast_q, outLast_d;
    logic             outStb_q, outStb_d;
    logic             bufWe;
    logic [FP_W-1:0]  bufRdata;
    logic             idxLast;

    assign idxLast = (idx_q == IDX_W'(N - 1));

    softmax_exp_buffer #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_exp_buffer (
        .clk     (clk),
        .we_i    (bufWe),
        .waddr_i (idx_q),
        .wdata_i (input_exp),
        .raddr_i (idx_q),
        .rdata_o (bufRdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD_EXP;
            idx_q     <= '0;
            sum_q     <= FP_ZERO;
            expAck_q  <= 1'b0;
            sumAck_q  <= 1'b0;
            divA_q    <= FP_ZERO;
            divAStb_q <= 1'b0;
            divB_q    <= FP_ZERO;
            divBStb_q <= 1'b0;
            zAck_q    <= 1'b0;
            outZ_q    <= FP_ZERO;
            outIdx_q  <= '0;
            outLast_q <= 1'b0;
            outStb_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            expAck_q  <= expAck_d;
            sumAck_q  <= sumAck_d;
            divA_q    <= divA_d;
            divAStb_q <= divAStb_d;
            divB_q    <= divB_d;
            divBStb_q <= divBStb_d;
            zAck_q    <= zAck_d;
            outZ_q    <= outZ_d;
            outIdx_q  <= outIdx_d;
            outLast_q <= outLast_d;
            outStb_q  <= outStb_d;
        end
    end

    // Acks and strobes are raised on the first cycle in their state and dropped on the transfer.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sum_d     = sum_q;
        expAck_d  = expAck_q;
        sumAck_d  = sumAck_q;
        divA_d    = divA_q;
        divAStb_d = divAStb_q;
        divB_d    = divB_q;
        divBStb_d = divBStb_q;
        zAck_d    = zAck_q;
        outZ_d    = outZ_q;
        outIdx_d  = outIdx_q;
        outLast_d = outLast_q;
        outStb_d  = outStb_q;
        bufWe     = 1'b0;

        case (state_q)
            LOAD_EXP: begin
                expAck_d = 1'b1;
                if (input_exp_stb && expAck_q) begin
                    bufWe    = 1'b1;
                    expAck_d = 1'b0;
                    if (idxLast) begin
                        idx_d   = '0;
                        state_d = LOAD_SUM;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            LOAD_SUM: begin
                sumAck_d = 1'b1;
                if (input_sum_stb && sumAck_q) begin
                    sum_d    = input_sum;
                    sumAck_d = 1'b0;
                    state_d  = SEND_A;
                end
            end
            SEND_A: begin
                divA_d    = bufRdata;
                divAStb_d = 1'b1;
                if (divAStb_q && div_a_ack) begin
                    divAStb_d = 1'b0;
                    state_d   = SEND_B;
                end
            end
            SEND_B: begin
                divB_d    = sum_q;
                divBStb_d = 1'b1;
                if (divBStb_q && div_b_ack) begin
                    divBStb_d = 1'b0;
                    state_d   = WAIT_Z;
                end
            end
            WAIT_Z: begin
                zAck_d = 1'b1;
                if (div_z_stb && zAck_q) begin
                    outZ_d    = div_z;
                    outIdx_d  = idx_q;
                    outLast_d = idxLast;
                    zAck_d    = 1'b0;
                    state_d   = PUT_Z;
                end
            end
            PUT_Z: begin
                outStb_d = 1'b1;
                if (outStb_q && output_z_ack) begin
                    outStb_d = 1'b0;
                    if (idxLast) begin
                        idx_d   = '0;
                        state_d = LOAD_EXP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = SEND_A;
                    end
                end
            end
            default: begin
                state_d = LOAD_EXP;
            end
        endcase
    end

    assign input_exp_ack = expAck_q;
    assign input_sum_ack = sumAck_q;
    assign div_a         = divA_q;
    assign div_a_stb     = divAStb_q;
    assign div_b         = divB_q;
    assign div_b_stb     = divBStb_q;
    assign div_z_ack     = zAck_q;
    assign output_z      = outZ_q;
    assign output_idx    = outIdx_q;
    assign output_last   = outLast_q;
    assign output_z_stb  = outStb_q;

endmodule

// File: tb/tb_softmax_div_feeder.sv
// Self-checking bench for softmax_div_feeder (N=4) with a stub divider that
// answers with random handshake latencies and a scoreboard on the output.
module tb_softmax_div_feeder;
    import softmax_pkg::*;

    localparam int N          = 4;
    localparam int IDX_W      = 2;
    localparam int WAIT_LIMIT = 3000;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      input_exp;
    logic             input_exp_stb;
    logic             input_exp_ack;
    logic [31:0]      input_sum;
    logic             input_sum_stb;
    logic             input_sum_ack;
    logic [31:0]      div_a;
    logic             div_a_stb;
    logic             div_a_ack;
    logic [31:0]      div_b;
    logic             div_b_stb;
    logic             div_b_ack;
    logic [31:0]      div_z;
    logic             div_z_stb;
    logic             div_z_ack;
    logic [31:0]      output_z;
    logic [IDX_W-1:0] output_idx;
    logic             output_last;
    logic             output_z_stb;
    logic             output_z_ack;

    typedef struct {
        logic [31:0]      z;
        logic [IDX_W-1:0] idx;
        logic             last;
    } out_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } div_t;

    out_t        outQ[$];
    div_t        divQ[$];
    logic [31:0] curExp [N];
    logic [31:0] curSum;
    int          assertCount = 0;
    int          failCount   = 0;
    int          expXfers    = 0;
    bit          holdZ       = 1'b0;
    bit          abortZ      = 1'b0;
    bit          stallOn     = 1'b0;

    softmax_div_feeder #(
        .N     (N),
        .IDX_W (IDX_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .input_exp     (input_exp),
        .input_exp_stb (input_exp_stb),
        .input_exp_ack (input_exp_ack),
        .input_sum     (input_sum),
        .input_sum_stb (input_sum_stb),
        .input_sum_ack (input_sum_ack),
        .div_a         (div_a),
        .div_a_stb     (div_a_stb),
        .div_a_ack     (div_a_ack),
        .div_b         (div_b),
        .div_b_stb     (div_b_stb),
        .div_b_ack     (div_b_ack),
        .div_z         (div_z),
        .div_z_stb     (div_z_stb),
        .div_z_ack     (div_z_ack),
        .output_z      (output_z),
        .output_idx    (output_idx),
        .output_last   (output_last),
        .output_z_stb  (output_z_stb),
        .output_z_ack  (output_z_ack)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Divider model: exact quotients for the test-plan operands, inf for x/0, scrambled tag otherwise.
    function automatic logic [31:0] divModel(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h41000000) begin
            case (a)
                32'h3F800000: return 32'h3E000000;
                32'h40000000: return 32'h3E800000;
                32'h40400000: return 32'h3EC00000;
                32'h40800000: return 32'h3F000000;
                default:      return a ^ {b[15:0], b[31:16]};
            endcase
        end
        if (b == FP_ZERO && a[30:23] != 8'h00 && a[30:23] != 8'hFF) begin
            return {a[31], 8'hFF, 23'h0};
        end
        return a ^ {b[15:0], b[31:16]};
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_exp_ack"}, 32'(input_exp_ack), 0);
        checkOutput({tag, "_sum_ack"}, 32'(input_sum_ack), 0);
        checkOutput({tag, "_a_stb"}, 32'(div_a_stb), 0);
        checkOutput({tag, "_b_stb"}, 32'(div_b_stb), 0);
        checkOutput({tag, "_z_ack"}, 32'(div_z_ack), 0);
        checkOutput({tag, "_out_stb"}, 32'(output_z_stb), 0);
        checkOutput({tag, "_div_a"}, div_a, 0);
        checkOutput({tag, "_div_b"}, div_b, 0);
        checkOutput({tag, "_out_z"}, output_z, 0);
        checkOutput({tag, "_out_idx"}, 32'(output_idx), 0);
        checkOutput({tag, "_out_last"}, 32'(output_last), 0);
    endtask

    task automatic sendSum();
        int n = 0;
        input_sum     = curSum;
        input_sum_stb = 1'b1;
        while (!input_sum_ack && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIMIT) checkOutput("sum_timeout", 0, 1);
        checkOutput("sum_gate", 32'(expXfers), N);
        @(posedge clk);
        @(negedge clk);
        input_sum_stb = 1'b0;
    endtask

    // Streams curExp then curSum; scoreboard entries are queued once the whole vector is in.
    task automatic applyStimulus(input bit earlySum);
        expXfers = 0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    int n = 0;
                    input_exp     = curExp[i];
                    input_exp_stb = 1'b1;
                    while (!input_exp_ack && n < WAIT_LIMIT) begin
                        @(negedge clk);
                        n++;
                    end
                    if (n >= WAIT_LIMIT) checkOutput("exp_timeout", 0, 1);
                    checkOutput("exp_gate", 32'(outQ.size()), 0);
                    @(posedge clk);
                    expXfers++;
                    @(negedge clk);
                end
                input_exp_stb = 1'b0;
                for (int i = 0; i < N; i++) begin
                    out_t o;
                    div_t d;
                    d.a  = curExp[i];
                    d.b  = curSum;
                    o.z  = divModel(curExp[i], curSum);
                    o.idx  = IDX_W'(i);
                    o.last = (i == N - 1);
                    divQ.push_back(d);
                    outQ.push_back(o);
                end
            end
            begin
                if (earlySum) sendSum();
            end
        join
        if (!earlySum) sendSum();
    endtask

    task automatic waitDrain();
        int n = 0;
        while (outQ.size() != 0 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIMIT) checkOutput("drain_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    // Stub divider: random 0-20 cycle latency on each channel, checks operands against the scoreboard.
    initial begin : divStub
        div_t req;
        div_a_ack = 1'b0;
        div_b_ack = 1'b0;
        div_z     = '0;
        div_z_stb = 1'b0;
        forever begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            while (!div_a_stb) @(negedge clk);
            checkOutput("a_excl", {30'b0, div_b_stb, output_z_stb}, 0);
            if (divQ.size() == 0) begin
                checkOutput("a_unexpected", 1, 0);
                req.a = div_a;
                req.b = '0;
            end else begin
                req = divQ.pop_front();
            end
            checkOutput("div_a", div_a, req.a);
            div_a_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            div_a_ack = 1'b0;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            while (!div_b_stb) @(negedge clk);
            checkOutput("div_b", div_b, req.b);
            div_b_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            div_b_ack = 1'b0;
            repeat ($urandom_range(0, 20)) @(negedge clk);
            while (holdZ && !abortZ) @(negedge clk);
            if (abortZ) begin
                abortZ = 1'b0;
                continue;
            end
            div_z     = divModel(req.a, req.b);
            div_z_stb = 1'b1;
            while (!div_z_ack) @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            div_z_stb = 1'b0;
        end
    end

    initial begin : collector
        out_t             expOut;
        logic [31:0]      zSnap;
        logic [IDX_W-1:0] idxSnap;
        output_z_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (output_z_stb) begin
                if (stallOn) begin
                    stallOn = 1'b0;
                    zSnap   = output_z;
                    idxSnap = output_idx;
                    repeat (10) begin
                        @(negedge clk);
                        checkOutput("bp_z", output_z, zSnap);
                        checkOutput("bp_idx", 32'(output_idx), 32'(idxSnap));
                        checkOutput("bp_stb", 32'(output_z_stb), 1);
                        checkOutput("bp_div_a_stb", 32'(div_a_stb), 0);
                    end
                end
                if (outQ.size() == 0) begin
                    checkOutput("out_unexpected", 1, 0);
                end else begin
                    expOut = outQ.pop_front();
                    checkOutput("out_z", output_z, expOut.z);
                    checkOutput("out_idx", 32'(output_idx), 32'(expOut.idx));
                    checkOutput("out_last", 32'(output_last), 32'(expOut.last));
                end
                output_z_ack = 1'b1;
                @(posedge clk);
                @(negedge clk);
                output_z_ack = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, observed hang, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : mainFlow
        int n;
        rst           = 1'b1;
        input_exp     = '0;
        input_exp_stb = 1'b0;
        input_sum     = '0;
        input_sum_stb = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_exp_ack_up", 32'(input_exp_ack), 1);

        $display("[TB] nominal vector");
        curExp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000};
        curSum = 32'h41000000;
        applyStimulus(1'b0);
        waitDrain();

        $display("[TB] early sum");
        curExp = '{32'h40800000, 32'h3F800000, 32'h40000000, 32'h40400000};
        applyStimulus(1'b1);
        waitDrain();

        $display("[TB] backpressure");
        stallOn = 1'b1;
        curExp  = '{32'h40400000, 32'h40800000, 32'h3F800000, 32'h40000000};
        applyStimulus(1'b0);
        waitDrain();

        $display("[TB] random pass-through");
        for (int i = 0; i < N; i++) curExp[i] = $urandom;
        curSum = $urandom;
        applyStimulus(1'b1);
        waitDrain();

        $display("[TB] reset during WAIT_Z");
        holdZ  = 1'b1;
        curExp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        curSum = 32'h41000000;
        applyStimulus(1'b0);
        n = 0;
        while (!div_z_ack && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= WAIT_LIMIT) checkOutput("wait_z_timeout", 0, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetState("midrst");
        outQ.delete();
        divQ.delete();
        abortZ = 1'b1;
        holdZ  = 1'b0;
        rst    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_exp_ack_up", 32'(input_exp_ack), 1);
        n = 0;
        while (abortZ && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        curExp = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3F800000};
        applyStimulus(1'b0);
        waitDrain();

        $display("[TB] back-to-back vectors, second with zero sum");
        curExp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40000000};
        curSum = 32'h41000000;
        applyStimulus(1'b0);
        curExp = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        curSum = FP_ZERO;
        applyStimulus(1'b0);
        waitDrain();

        checkOutput("final_div_queue_empty", 32'(divQ.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
